// File: rtl/recepcao_serial_face_if.sv
// Face receiver bus: serial line, arming strobe, status flags and the matrix read port.
// Pure wiring; no handshake or backpressure on this interface.
interface recepcao_serial_face_if;
  logic       iniciar;
  logic       entrada_serial;
  logic [1:0] addr_linha;
  logic [1:0] addr_coluna;
  logic [2:0] dado_pixel;
  logic       recebendo;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    output iniciar, entrada_serial, addr_linha, addr_coluna,
    input  dado_pixel, recebendo, pronto, erro, db_estado
  );

  modport slave (
    input  iniciar, entrada_serial, addr_linha, addr_coluna,
    output dado_pixel, recebendo, pronto, erro, db_estado
  );
endinterface

// File: rtl/recepcao_serial_face.sv
// UART 8N1 receiver that rebuilds a N_LINHAS x N_COLUNAS face of 3-bit colours; line input has 2 cycles sync latency,
// read port is combinational; no backpressure, bytes arriving while the face is complete are ignored.
module recepcao_serial_face #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_LINHAS     = 3,
  parameter int N_COLUNAS    = 3
) (
  input logic clock,
  input logic reset,
  recepcao_serial_face_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARA      = 4'd1,
    ESPERA_START = 4'd2,
    CONFIRMA     = 4'd3,
    RECEBE       = 4'd4,
    STOP         = 4'd5,
    ESPERA_LINHA = 4'd6,
    ARMAZENA     = 4'd7,
    PROXIMO      = 4'd8,
    FIM          = 4'd9
  } estado_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MEIO_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]    ULT_LIN  = 2'(N_LINHAS - 1);
  localparam logic [1:0]    ULT_COL  = 2'(N_COLUNAS - 1);

  estado_t       estado, prox_estado;
  logic          rx_meta, rx;
  logic [CW-1:0] cnt_baud;
  logic [2:0]    cnt_bit;
  logic [1:0]    linha, coluna;
  logic [7:0]    dado_rx;
  logic          pronto_r, erro_r;
  logic [2:0]    matriz [N_LINHAS][N_COLUNAS];

  logic baud_fim, meio_fim, ultimo_pixel;
  assign baud_fim     = (cnt_baud == FIM_BIT);
  assign meio_fim     = (cnt_baud == MEIO_BIT);
  assign ultimo_pixel = (linha == ULT_LIN) && (coluna == ULT_COL);

  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox_estado;
  end

  // iniciar overrides every state so a face in progress can be abandoned
  always_comb begin
    prox_estado = estado;
    if (bus.iniciar) begin
      prox_estado = PREPARA;
    end else begin
      case (estado)
        INICIAL, FIM: prox_estado = estado;
        PREPARA:      prox_estado = ESPERA_START;
        ESPERA_START: if (!rx) prox_estado = CONFIRMA;
        CONFIRMA:     if (meio_fim) prox_estado = rx ? ESPERA_START : RECEBE;
        RECEBE:       if (baud_fim && cnt_bit == 3'd7) prox_estado = STOP;
        STOP:         if (baud_fim) prox_estado = rx ? ARMAZENA : ESPERA_LINHA;
        ESPERA_LINHA: if (rx) prox_estado = ESPERA_START;
        ARMAZENA:     prox_estado = PROXIMO;
        PROXIMO:      prox_estado = ultimo_pixel ? FIM : ESPERA_START;
        default:      prox_estado = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx       <= 1'b1;
      cnt_baud <= '0;
      cnt_bit  <= '0;
      linha    <= '0;
      coluna   <= '0;
      dado_rx  <= '0;
      pronto_r <= 1'b0;
      erro_r   <= 1'b0;
      for (int l = 0; l < N_LINHAS; l++)
        for (int c = 0; c < N_COLUNAS; c++)
          matriz[l][c] <= '0;
    end else begin
      rx_meta <= bus.entrada_serial;
      rx      <= rx_meta;

      if (estado == CONFIRMA)
        cnt_baud <= meio_fim ? '0 : cnt_baud + 1'b1;
      else if (estado == RECEBE || estado == STOP)
        cnt_baud <= baud_fim ? '0 : cnt_baud + 1'b1;
      else
        cnt_baud <= '0;

      case (estado)
        PREPARA: begin
          linha    <= '0;
          coluna   <= '0;
          cnt_bit  <= '0;
          pronto_r <= 1'b0;
          erro_r   <= 1'b0;
        end
        CONFIRMA: cnt_bit <= '0;
        RECEBE: begin
          if (baud_fim) begin
            dado_rx <= {rx, dado_rx[7:1]};
            cnt_bit <= cnt_bit + 3'd1;
          end
        end
        STOP: if (baud_fim && !rx) erro_r <= 1'b1;
        ARMAZENA: begin
          matriz[linha][coluna] <= dado_rx[2:0];
          if (|dado_rx[7:3]) erro_r <= 1'b1;
        end
        PROXIMO: begin
          if (!ultimo_pixel) begin
            if (coluna == ULT_COL) begin
              coluna <= '0;
              linha  <= linha + 2'd1;
            end else begin
              coluna <= coluna + 2'd1;
            end
          end
        end
        FIM: pronto_r <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.dado_pixel = 3'b000;
    if (int'(bus.addr_linha) < N_LINHAS && int'(bus.addr_coluna) < N_COLUNAS)
      bus.dado_pixel = matriz[bus.addr_linha][bus.addr_coluna];
  end

  assign bus.recebendo = (estado == CONFIRMA) || (estado == RECEBE) || (estado == STOP);
  assign bus.pronto    = pronto_r;
  assign bus.erro      = erro_r;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_recepcao_serial_face.sv
// Directed bench for recepcao_serial_face with CLKS_PER_BIT=8 and a 3x3 face.
module tb_recepcao_serial_face;

  localparam int CPB = 8;

  logic clock = 1'b0;
  logic reset;
  int   vetores = 0;
  int   erros   = 0;

  recepcao_serial_face_if bus ();

  recepcao_serial_face #(
    .CLKS_PER_BIT(CPB),
    .N_LINHAS(3),
    .N_COLUNAS(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ler(input logic [1:0] l, input logic [1:0] c, output logic [2:0] v);
    bus.addr_linha  = l;
    bus.addr_coluna = c;
    #1;
    v = bus.dado_pixel;
  endtask

  // Line is left at the stop value; a bad stop keeps it low until the caller releases it.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bus.entrada_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.entrada_serial = b[i];
      tick(CPB);
    end
    bus.entrada_serial = stop_ok;
    tick(CPB);
  endtask

  task automatic pulso_iniciar();
    bus.iniciar = 1'b1;
    tick(1);
    bus.iniciar = 1'b0;
    tick(1);
  endtask

  task automatic pulso_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] v;
    reset = 1'b0;
    bus.iniciar = 1'b0;
    bus.entrada_serial = 1'b1;
    bus.addr_linha = 2'd0;
    bus.addr_coluna = 2'd0;
    tick(2);
    vetores++; if (bus.db_estado !== 4'd0) begin erros++; $display("FAIL reset_estado got %0d want 0", bus.db_estado); end
    vetores++; if (bus.pronto !== 1'b0) begin erros++; $display("FAIL reset_pronto got %b want 0", bus.pronto); end
    vetores++; if (bus.erro !== 1'b0) begin erros++; $display("FAIL reset_erro got %b want 0", bus.erro); end
    vetores++; if (bus.recebendo !== 1'b0) begin erros++; $display("FAIL reset_recebendo got %b want 0", bus.recebendo); end
    ler(2'd1, 2'd1, v);
    vetores++; if (v !== 3'd0) begin erros++; $display("FAIL reset_pixel got %0d want 0", v); end
    reset = 1'b1;
    tick(1);
    vetores++; if (bus.db_estado !== 4'd0) begin erros++; $display("FAIL idle_estado got %0d want 0", bus.db_estado); end
  endtask

  task automatic test_face_completa();
    logic [7:0] seq [9];
    logic [2:0] v;
    seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'h02, 8'h03};
    pulso_iniciar();
    for (int i = 0; i < 9; i++) send_byte(seq[i], 1'b1);
    tick(1);
    vetores++; if (bus.db_estado !== 4'd9) begin erros++; $display("FAIL face_estado_fim got %0d want 9", bus.db_estado); end
    vetores++; if (bus.pronto !== 1'b0) begin erros++; $display("FAIL face_pronto_cedo got %b want 0", bus.pronto); end
    tick(1);
    vetores++; if (bus.pronto !== 1'b1) begin erros++; $display("FAIL face_pronto got %b want 1", bus.pronto); end
    vetores++; if (bus.erro !== 1'b0) begin erros++; $display("FAIL face_erro got %b want 0", bus.erro); end
    for (int i = 0; i < 9; i++) begin
      ler(2'(i / 3), 2'(i % 3), v);
      vetores++;
      if (v !== seq[i][2:0]) begin erros++; $display("FAIL face_pixel(%0d,%0d) got %0d want %0d", i / 3, i % 3, v, seq[i][2:0]); end
    end
    ler(2'd3, 2'd0, v);
    vetores++; if (v !== 3'd0) begin erros++; $display("FAIL face_fora_linha got %0d want 0", v); end
    ler(2'd1, 2'd3, v);
    vetores++; if (v !== 3'd0) begin erros++; $display("FAIL face_fora_coluna got %0d want 0", v); end
  endtask

  // Runs on top of the completed face from test_face_completa.
  task automatic test_reinicio();
    logic [2:0] v;
    pulso_iniciar();
    vetores++; if (bus.pronto !== 1'b0) begin erros++; $display("FAIL reinicio_pronto got %b want 0", bus.pronto); end
    vetores++; if (bus.db_estado !== 4'd2) begin erros++; $display("FAIL reinicio_estado got %0d want 2", bus.db_estado); end
    send_byte(8'h07, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h06, 1'b1);
    ler(2'd1, 2'd0, v);
    vetores++; if (v !== 3'd6) begin erros++; $display("FAIL reinicio_pix10 got %0d want 6", v); end
    ler(2'd1, 2'd1, v);
    vetores++; if (v !== 3'd4) begin erros++; $display("FAIL reinicio_pix11_antigo got %0d want 4", v); end
    pulso_iniciar();
    vetores++; if (bus.pronto !== 1'b0) begin erros++; $display("FAIL reinicio2_pronto got %b want 0", bus.pronto); end
    ler(2'd0, 2'd0, v);
    vetores++; if (v !== 3'd7) begin erros++; $display("FAIL reinicio_pix00_mantido got %0d want 7", v); end
    send_byte(8'h01, 1'b1);
    ler(2'd0, 2'd0, v);
    vetores++; if (v !== 3'd1) begin erros++; $display("FAIL reinicio_pix00_novo got %0d want 1", v); end
    ler(2'd0, 2'd1, v);
    vetores++; if (v !== 3'd6) begin erros++; $display("FAIL reinicio_pix01_mantido got %0d want 6", v); end
  endtask

  task automatic test_glitch();
    logic [2:0] v;
    pulso_reset();
    pulso_iniciar();
    bus.entrada_serial = 1'b0;
    tick(2);
    bus.entrada_serial = 1'b1;
    tick(2);
    vetores++; if (bus.recebendo !== 1'b1) begin erros++; $display("FAIL glitch_confirma got %b want 1", bus.recebendo); end
    tick(8);
    vetores++; if (bus.db_estado !== 4'd2) begin erros++; $display("FAIL glitch_estado got %0d want 2", bus.db_estado); end
    vetores++; if (bus.erro !== 1'b0) begin erros++; $display("FAIL glitch_erro got %b want 0", bus.erro); end
    send_byte(8'h04, 1'b1);
    send_byte(8'h03, 1'b1);
    ler(2'd0, 2'd0, v);
    vetores++; if (v !== 3'd4) begin erros++; $display("FAIL glitch_pix00 got %0d want 4", v); end
    ler(2'd0, 2'd1, v);
    vetores++; if (v !== 3'd3) begin erros++; $display("FAIL glitch_pix01 got %0d want 3", v); end
  endtask

  task automatic test_stop_invalido();
    logic [2:0] v;
    pulso_reset();
    pulso_iniciar();
    send_byte(8'h02, 1'b0);
    vetores++; if (bus.db_estado !== 4'd6) begin erros++; $display("FAIL stop_estado got %0d want 6", bus.db_estado); end
    vetores++; if (bus.erro !== 1'b1) begin erros++; $display("FAIL stop_erro got %b want 1", bus.erro); end
    bus.entrada_serial = 1'b1;
    tick(CPB);
    ler(2'd0, 2'd0, v);
    vetores++; if (v !== 3'd0) begin erros++; $display("FAIL stop_sem_escrita got %0d want 0", v); end
    send_byte(8'h06, 1'b1);
    ler(2'd0, 2'd0, v);
    vetores++; if (v !== 3'd6) begin erros++; $display("FAIL stop_pix00 got %0d want 6", v); end
    ler(2'd0, 2'd1, v);
    vetores++; if (v !== 3'd0) begin erros++; $display("FAIL stop_pix01 got %0d want 0", v); end
    vetores++; if (bus.erro !== 1'b1) begin erros++; $display("FAIL stop_erro_sticky got %b want 1", bus.erro); end
  endtask

  task automatic test_bits_altos();
    logic [2:0] v;
    pulso_reset();
    pulso_iniciar();
    send_byte(8'h1D, 1'b1);
    vetores++; if (bus.erro !== 1'b1) begin erros++; $display("FAIL altos_erro got %b want 1", bus.erro); end
    ler(2'd0, 2'd0, v);
    vetores++; if (v !== 3'd5) begin erros++; $display("FAIL altos_pix00 got %0d want 5", v); end
    send_byte(8'h02, 1'b1);
    ler(2'd0, 2'd1, v);
    vetores++; if (v !== 3'd2) begin erros++; $display("FAIL altos_pix01 got %0d want 2", v); end
    vetores++; if (bus.erro !== 1'b1) begin erros++; $display("FAIL altos_erro_sticky got %b want 1", bus.erro); end
    pulso_iniciar();
    vetores++; if (bus.erro !== 1'b0) begin erros++; $display("FAIL altos_erro_limpo got %b want 0", bus.erro); end
  endtask

  task automatic test_reset_meio();
    logic [2:0] v;
    pulso_reset();
    pulso_iniciar();
    send_byte(8'h03, 1'b1);
    send_byte(8'h05, 1'b1);
    bus.entrada_serial = 1'b0;
    tick(CPB);
    bus.entrada_serial = 1'b1;
    tick(CPB);
    bus.entrada_serial = 1'b0;
    tick(CPB);
    vetores++; if (bus.db_estado !== 4'd4) begin erros++; $display("FAIL meio_estado_recebe got %0d want 4", bus.db_estado); end
    vetores++; if (bus.recebendo !== 1'b1) begin erros++; $display("FAIL meio_recebendo got %b want 1", bus.recebendo); end
    ler(2'd0, 2'd1, v);
    vetores++; if (v !== 3'd5) begin erros++; $display("FAIL meio_pix01 got %0d want 5", v); end
    reset = 1'b0;
    tick(1);
    vetores++; if (bus.db_estado !== 4'd0) begin erros++; $display("FAIL meio_reset_estado got %0d want 0", bus.db_estado); end
    vetores++; if (bus.recebendo !== 1'b0) begin erros++; $display("FAIL meio_reset_recebendo got %b want 0", bus.recebendo); end
    vetores++; if (bus.pronto !== 1'b0) begin erros++; $display("FAIL meio_reset_pronto got %b want 0", bus.pronto); end
    for (int i = 0; i < 9; i++) begin
      ler(2'(i / 3), 2'(i % 3), v);
      vetores++;
      if (v !== 3'd0) begin erros++; $display("FAIL meio_reset_pixel(%0d,%0d) got %0d want 0", i / 3, i % 3, v); end
    end
    bus.entrada_serial = 1'b1;
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_face_completa();
    test_reinicio();
    test_glitch();
    test_stop_invalido();
    test_bits_altos();
    test_reset_meio();
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
